// File: rtl/data_expand_pkg.sv
// Shared lane constants, the per-lane select/fill configuration type and the
// disabledGroups -> configuration mapping (reusable by the capture-side compactor).
package data_expand_pkg;

    localparam int unsigned NumGroups = 4;
    localparam int unsigned LaneW     = 8;
    localparam int unsigned DataW     = NumGroups * LaneW;

    typedef struct packed {
        logic [NumGroups-1:0][1:0] outsel;
        logic [NumGroups-1:0]      fill;
    } lane_cfg_t;

    localparam lane_cfg_t PassCfg = lane_cfg_t'({8'b11_10_01_00, 4'b0000});

    // Enabled lane g takes the compacted byte whose index equals the number of
    // enabled groups below g; all-enabled and all-disabled both mean pass-through.
    function automatic lane_cfg_t cfg_from_disabled(input logic [NumGroups-1:0] dis);
        lane_cfg_t  cfg;
        logic [1:0] idx;
        cfg = PassCfg;
        idx = 2'd0;
        if (dis != '0 && dis != '1) begin
            for (int unsigned g = 0; g < NumGroups; g++) begin
                cfg.fill[g]   = dis[g];
                cfg.outsel[g] = dis[g] ? 2'(g) : idx;
                if (!dis[g]) begin
                    idx = idx + 2'd1;
                end
            end
        end
        return cfg;
    endfunction

endpackage

// File: rtl/data_expand_buf.sv
// Two-entry valid/ready FIFO with head/tail pointers and an occupancy count.
// When drained, the head stays on the last popped entry so the output holds.
module data_expand_buf #(
    parameter int unsigned Width = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push_valid_i,
    output logic             push_ready_o,
    input  logic [Width-1:0] push_data_i,
    output logic             pop_valid_o,
    input  logic             pop_ready_i,
    output logic [Width-1:0] pop_data_o,
    output logic [1:0]       count_o
);

    logic [1:0][Width-1:0] mem_q, mem_d;
    logic                  head_q, head_d;
    logic                  tail_q, tail_d;
    logic [1:0]            count_q, count_d;
    logic                  push, pop;

    assign push_ready_o = (count_q != 2'd2);
    assign pop_valid_o  = (count_q != 2'd0);
    assign pop_data_o   = mem_q[head_q];
    assign count_o      = count_q;

    assign push = push_valid_i && push_ready_o;
    assign pop  = pop_valid_o && pop_ready_i;

    always_comb begin
        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (push) begin
            mem_d[tail_q] = push_data_i;
            tail_d        = ~tail_q;
        end
        if (pop) begin
            if (!push && count_q == 2'd1) begin
                // Keep head on the last entry and pull tail back onto it.
                tail_d = head_q;
            end else begin
                head_d = ~head_q;
            end
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mem_q   <= '0;
            head_q  <= 1'b0;
            tail_q  <= 1'b0;
            count_q <= 2'd0;
        end else begin
            mem_q   <= mem_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/data_expand.sv
// Re-expands compacted sample words into full 32-bit samples behind a 2-entry buffer.
// Optional emitted-word counter enabled by defining DATA_EXPAND_CNT_EN.
module data_expand
    import data_expand_pkg::*;
#(
    parameter logic [7:0]  FILL_BYTE = 8'h00,
    parameter int unsigned CNT_W     = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [3:0]       disabledGroups,
    input  logic             validIn,
    output logic             readyIn,
    input  logic [31:0]      dataIn,
    output logic             validOut,
    input  logic             readyOut,
    output logic [31:0]      dataOut,
    output logic             idle,
    output logic [CNT_W-1:0] wordCount
);

    lane_cfg_t                          cfg_q, cfg_d, cfg_new;
    logic                               accept;
    logic                               cfg_load;
    logic [1:0]                         count;
    logic [NumGroups-1:0][LaneW-1:0]    in_lanes, out_lanes;

    assign in_lanes = dataIn;
    assign accept   = validIn && readyIn;
    assign idle     = (count == 2'd0);
    assign cfg_new  = cfg_from_disabled(disabledGroups);
    // Only reload when nothing is buffered or arriving, so no word mixes mappings.
    assign cfg_load = idle && !accept;

    always_comb begin
        cfg_d = cfg_q;
        if (cfg_load) begin
            cfg_d = cfg_new;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cfg_q <= PassCfg;
        end else begin
            cfg_q <= cfg_d;
        end
    end

    always_comb begin
        out_lanes = '0;
        for (int unsigned g = 0; g < NumGroups; g++) begin
            out_lanes[g] = cfg_q.fill[g] ? FILL_BYTE : in_lanes[cfg_q.outsel[g]];
        end
    end

    data_expand_buf #(
        .Width (DataW)
    ) u_buf (
        .clock        (clock),
        .reset        (reset),
        .push_valid_i (validIn),
        .push_ready_o (readyIn),
        .push_data_i  (out_lanes),
        .pop_valid_o  (validOut),
        .pop_ready_i  (readyOut),
        .pop_data_o   (dataOut),
        .count_o      (count)
    );

`ifdef DATA_EXPAND_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (cfg_load && (cfg_new != cfg_q)) begin
            cnt_d = '0;
        end else if (validOut && readyOut) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign wordCount = cnt_q;
`else
    assign wordCount = '0;
`endif

endmodule

// File: tb/tb_data_expand.sv
// Randomized self-checking bench for data_expand against a byte-level reference model.
module tb_data_expand;

    localparam logic [7:0] Fill = 8'hFF;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  disabledGroups = 4'h0;
    logic        validIn = 1'b0;
    logic        readyIn;
    logic [31:0] dataIn = '0;
    logic        validOut;
    logic        readyOut = 1'b0;
    logic [31:0] dataOut;
    logic        idle;
    logic [31:0] wordCount;

    int checks   = 0;
    int failures = 0;

    data_expand #(
        .FILL_BYTE (Fill),
        .CNT_W     (32)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .disabledGroups (disabledGroups),
        .validIn        (validIn),
        .readyIn        (readyIn),
        .dataIn         (dataIn),
        .validOut       (validOut),
        .readyOut       (readyOut),
        .dataOut        (dataOut),
        .idle           (idle),
        .wordCount      (wordCount)
    );

    always #5 clock = ~clock;

    // Walk the output lanes; each enabled lane consumes the next compacted byte.
    function automatic logic [31:0] model(input logic [3:0] dis, input logic [31:0] d);
        logic [31:0] r;
        int          k;
        if (dis == 4'h0 || dis == 4'hF) return d;
        r = '0;
        k = 0;
        for (int g = 0; g < 4; g++) begin
            if (dis[g]) begin
                r[g*8 +: 8] = Fill;
            end else begin
                r[g*8 +: 8] = d[k*8 +: 8];
                k++;
            end
        end
        return r;
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic load_cfg(input logic [3:0] dis);
        validIn        = 1'b0;
        disabledGroups = dis;
        step();
    endtask

    task automatic test_reset();
        #1 reset = 1'b1;
        #1;
        checks += 5;
        if (validOut !== 1'b0) begin failures++; $display("FAIL reset_validOut got=%b want=0", validOut); end
        if (readyIn !== 1'b1) begin failures++; $display("FAIL reset_readyIn got=%b want=1", readyIn); end
        if (idle !== 1'b1) begin failures++; $display("FAIL reset_idle got=%b want=1", idle); end
        if (dataOut !== 32'h0) begin failures++; $display("FAIL reset_dataOut got=%h want=0", dataOut); end
        if (wordCount !== 32'h0) begin failures++; $display("FAIL reset_wordCount got=%0d want=0", wordCount); end
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic test_directed();
        logic [3:0]  dis_t [6] = '{4'b0111, 4'b0101, 4'b0000, 4'b1111, 4'b1000, 4'b0110};
        logic [31:0] din_t [6] = '{32'h000000A5, 32'h0000B2C1, 32'h12345678, 32'h12345678,
                                   32'h00AABBCC, 32'h0000DDEE};
        logic [31:0] exp_t [6] = '{32'hA5FFFFFF, 32'hB2FFC1FF, 32'h12345678, 32'h12345678,
                                   32'hFFAABBCC, 32'hDDFFFFEE};
        for (int i = 0; i < 6; i++) begin
            load_cfg(dis_t[i]);
            readyOut = 1'b1;
            validIn  = 1'b1;
            dataIn   = din_t[i];
            step();
            validIn = 1'b0;
            checks += 2;
            if (validOut !== 1'b1) begin failures++; $display("FAIL dir%0d_validOut got=%b want=1", i, validOut); end
            if (dataOut !== exp_t[i]) begin failures++; $display("FAIL dir%0d_dataOut dis=%b got=%h want=%h", i, dis_t[i], dataOut, exp_t[i]); end
            step();
            checks += 2;
            if (idle !== 1'b1 || validOut !== 1'b0) begin failures++; $display("FAIL dir%0d_drain idle=%b validOut=%b want 1/0", i, idle, validOut); end
            if (dataOut !== exp_t[i]) begin failures++; $display("FAIL dir%0d_hold got=%h want=%h", i, dataOut, exp_t[i]); end
        end
    endtask

    task automatic test_random_map();
        logic [3:0]  dis;
        logic [31:0] din, expv;
        for (int i = 0; i < 20; i++) begin
            dis  = 4'($urandom);
            din  = $urandom;
            expv = model(dis, din);
            load_cfg(dis);
            readyOut = 1'b1;
            validIn  = 1'b1;
            dataIn   = din;
            step();
            validIn = 1'b0;
            checks++;
            if (validOut !== 1'b1 || dataOut !== expv) begin
                failures++;
                $display("FAIL rmap dis=%b din=%h got=%h v=%b want=%h", dis, din, dataOut, validOut, expv);
            end
            step();
        end
    endtask

    task automatic test_back_to_back();
        load_cfg(4'h0);
        readyOut = 1'b0;
        validIn  = 1'b1;
        dataIn   = 32'd1;
        step();
        dataIn = 32'd2;
        step();
        checks += 2;
        if (readyIn !== 1'b0) begin failures++; $display("FAIL b2b_full_readyIn got=%b want=0", readyIn); end
        if (dataOut !== 32'd1 || validOut !== 1'b1) begin failures++; $display("FAIL b2b_head got=%h want=1", dataOut); end
        dataIn = 32'd3;
        step();
        checks++;
        if (readyIn !== 1'b0 || dataOut !== 32'd1) begin failures++; $display("FAIL b2b_stall readyIn=%b dataOut=%h want 0/1", readyIn, dataOut); end
        readyOut = 1'b1;
        step();
        checks++;
        if (dataOut !== 32'd2 || readyIn !== 1'b1) begin failures++; $display("FAIL b2b_out2 got=%h readyIn=%b want 2/1", dataOut, readyIn); end
        step();
        validIn = 1'b0;
        checks++;
        if (dataOut !== 32'd3 || validOut !== 1'b1) begin failures++; $display("FAIL b2b_out3 got=%h want=3", dataOut); end
        step();
        checks++;
        if (idle !== 1'b1 || validOut !== 1'b0) begin failures++; $display("FAIL b2b_idle idle=%b validOut=%b want 1/0", idle, validOut); end
    endtask

    task automatic test_config_change();
        logic [3:0]  da = 4'b0011;
        logic [3:0]  db = 4'b1100;
        logic [31:0] w1 = $urandom;
        logic [31:0] w2 = $urandom;
        logic [31:0] w3 = $urandom;
        load_cfg(da);
        readyOut = 1'b0;
        validIn  = 1'b1;
        dataIn   = w1;
        step();
        validIn        = 1'b0;
        disabledGroups = db;
        step();
        step();
        checks++;
        if (dataOut !== model(da, w1)) begin failures++; $display("FAIL cfg_inflight got=%h want=%h", dataOut, model(da, w1)); end
        validIn = 1'b1;
        dataIn  = w2;
        step();
        validIn  = 1'b0;
        readyOut = 1'b1;
        step();
        checks++;
        if (dataOut !== model(da, w2)) begin failures++; $display("FAIL cfg_nonidle got=%h want=%h", dataOut, model(da, w2)); end
        step();
        step();
        validIn = 1'b1;
        dataIn  = w3;
        step();
        validIn = 1'b0;
        checks++;
        if (dataOut !== model(db, w3)) begin failures++; $display("FAIL cfg_new got=%h want=%h", dataOut, model(db, w3)); end
        step();
    endtask

    task automatic test_random_stream();
        logic [31:0] q[$];
        logic [3:0]  dis;
        logic [31:0] expv;
        logic        acc;
        for (int r = 0; r < 6; r++) begin
            dis = 4'($urandom);
            load_cfg(dis);
            for (int c = 0; c < 60; c++) begin
                validIn  = 1'($urandom);
                readyOut = 1'($urandom);
                dataIn   = $urandom;
                checks += 2;
                if (readyIn !== (q.size() < 2)) begin failures++; $display("FAIL stream_readyIn got=%b size=%0d", readyIn, q.size()); end
                if (validOut !== (q.size() != 0)) begin failures++; $display("FAIL stream_validOut got=%b size=%0d", validOut, q.size()); end
                acc = validIn && (q.size() < 2);
                if (readyOut && q.size() != 0) begin
                    expv = q.pop_front();
                    checks++;
                    if (dataOut !== expv) begin failures++; $display("FAIL stream_data dis=%b got=%h want=%h", dis, dataOut, expv); end
                end
                if (acc) q.push_back(model(dis, dataIn));
                step();
            end
            validIn  = 1'b0;
            readyOut = 1'b1;
            for (int c = 0; c < 4 && q.size() != 0; c++) begin
                expv = q.pop_front();
                checks++;
                if (validOut !== 1'b1 || dataOut !== expv) begin failures++; $display("FAIL drain_data got=%h want=%h", dataOut, expv); end
                step();
            end
            checks++;
            if (q.size() != 0 || idle !== 1'b1) begin
                failures++;
                $display("FAIL drain_idle idle=%b left=%0d want 1/0", idle, q.size());
                q.delete();
            end
        end
    endtask

    task automatic test_reset_midstream();
        logic [31:0] w = $urandom;
        load_cfg(4'h0);
        readyOut = 1'b0;
        validIn  = 1'b1;
        dataIn   = 32'hDEAD0001;
        step();
        dataIn = 32'hDEAD0002;
        step();
        validIn = 1'b0;
        checks++;
        if (readyIn !== 1'b0) begin failures++; $display("FAIL mid_full readyIn=%b want=0", readyIn); end
        #2 reset = 1'b1;
        #1;
        checks += 3;
        if (validOut !== 1'b0) begin failures++; $display("FAIL mid_validOut got=%b want=0", validOut); end
        if (readyIn !== 1'b1) begin failures++; $display("FAIL mid_readyIn got=%b want=1", readyIn); end
        if (idle !== 1'b1) begin failures++; $display("FAIL mid_idle got=%b want=1", idle); end
        step();
        reset = 1'b0;
        step();
        readyOut = 1'b1;
        validIn  = 1'b1;
        dataIn   = w;
        step();
        validIn = 1'b0;
        checks++;
        if (dataOut !== w || validOut !== 1'b1) begin failures++; $display("FAIL mid_after got=%h want=%h", dataOut, w); end
        step();
        checks++;
        if (idle !== 1'b1) begin failures++; $display("FAIL mid_nostale idle=%b want=1", idle); end
    endtask

    task automatic test_counter();
`ifdef DATA_EXPAND_CNT_EN
        reset = 1'b1;
        step();
        reset = 1'b0;
        load_cfg(4'b0001);
        readyOut = 1'b1;
        for (int i = 0; i < 5; i++) begin
            validIn = 1'b1;
            dataIn  = $urandom;
            step();
        end
        validIn = 1'b0;
        step();
        checks++;
        if (wordCount !== 32'd5) begin failures++; $display("FAIL cnt_five got=%0d want=5", wordCount); end
        step();
        checks++;
        if (wordCount !== 32'd5) begin failures++; $display("FAIL cnt_same_cfg got=%0d want=5", wordCount); end
        load_cfg(4'b0010);
        checks++;
        if (wordCount !== 32'd0) begin failures++; $display("FAIL cnt_cfg_clear got=%0d want=0", wordCount); end
        validIn = 1'b1;
        step();
        step();
        validIn = 1'b0;
        step();
        checks++;
        if (wordCount !== 32'd2) begin failures++; $display("FAIL cnt_two got=%0d want=2", wordCount); end
        reset = 1'b1;
        #1;
        checks++;
        if (wordCount !== 32'd0) begin failures++; $display("FAIL cnt_reset got=%0d want=0", wordCount); end
        step();
        reset = 1'b0;
        step();
`else
        checks++;
        if (wordCount !== 32'd0) begin failures++; $display("FAIL cnt_tied got=%0d want=0", wordCount); end
`endif
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random_map();
        test_back_to_back();
        test_config_change();
        test_random_stream();
        test_reset_midstream();
        test_counter();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
